seq_mac_v2: RTL and testbench
=============================

SEQ_MAC_V2 -- requirements
Module: seq_mac_v2

Interface
REQ-001 SHALL have parameter M, default 2: rows of A and D.
REQ-002 SHALL have parameter N, default 2: columns of B and D.
REQ-003 SHALL have parameter K, default 2: reduction depth.
REQ-004 SHALL have parameter MAX_WIDTH, default 16: maximum operand width; legal range 2..16.
REQ-005 SHALL have parameter P, default 2: B bits consumed per cycle; legal values 1, 2, 4.
REQ-006 SHALL have parameter SATURATE, default 0: 1 = saturating accumulation, 0 = wrapping accumulation.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port a_i, input, [M][K] x MAX_WIDTH: A operands, right-aligned.
REQ-010 SHALL have port b_i, input, [K][N] x MAX_WIDTH: B operands, right-aligned.
REQ-011 SHALL have port c_i, input, [M][N] x 32: C addend (signed).
REQ-012 SHALL have port size_a_i, input, 5 bits: A width, 1..MAX_WIDTH.
REQ-013 SHALL have port size_b_i, input, 5 bits: B width, 1..MAX_WIDTH.
REQ-014 SHALL have port signed_a_i, input, 1 bit: 1 = A signed, 0 = A unsigned.
REQ-015 SHALL have port signed_b_i, input, 1 bit: 1 = B signed, 0 = B unsigned.
REQ-016 SHALL have port accum_i, input, 1 bit: 1 = start from the current D instead of c_i.
REQ-017 SHALL have ports valid_i (input, 1 bit) and ready_o (output, 1 bit): input handshake.
REQ-018 SHALL have ports valid_o (output, 1 bit) and ready_i (input, 1 bit): output handshake.
REQ-019 SHALL have port d_o, output, [M][N] x 32: result D = A*B + C (or A*B + D).

Function
REQ-020 SHALL implement an FSM with states IDLE, COMPUTE and DONE.
REQ-021 SHALL assert ready_o in IDLE, and in DONE while ready_i=1; ready_o SHALL be 0 in COMPUTE.
REQ-022 SHALL accept a job when valid_i & ready_o; on acceptance, register a_i, b_i, sizes, sign flags and accum_i.
REQ-023 SHALL load each accumulator with c_i on acceptance, or leave it holding d_o when accum_i=1.
REQ-024 SHALL sign-extend (signed) or zero-extend (unsigned) each operand from its size_* width; bits above size_* SHALL be ignored.
REQ-025 SHALL compute NCH = ceil(size_b/P) and extend B to NCH*P bits.
REQ-026 SHALL process chunk j (j = 0..NCH-1, LSB first) in COMPUTE cycle j, as follows:
- per lane, sum over k of A[m][k] * chunk_j(B[k][n]);
- shift the sum left by j*P;
- add it into the accumulator.
REQ-027 SHALL treat chunk NCH-1 as a signed P-bit value when signed_b=1, and every other chunk as unsigned.
REQ-028 SHALL form lane partial sums exactly, at width MAX_WIDTH+P+2+clog2(K), with no truncation.
REQ-029 SHALL reduce into the 32-bit accumulator in one of two ways:
- SATURATE=1: clamp to [-2^31, 2^31-1];
- SATURATE=0: wrap modulo 2^32.
REQ-030 SHALL transition COMPUTE -> DONE after chunk NCH-1.
REQ-031 SHALL assert valid_o only in DONE, beginning the cycle after the last chunk; latency from acceptance to valid_o is NCH+1 cycles.
REQ-032 SHALL hold d_o and valid_o stable in DONE while ready_i=0.
REQ-033 SHALL transition DONE -> IDLE on ready_i=1 & valid_i=0, and DONE -> COMPUTE on ready_i=1 & valid_i=1 (back-to-back, no bubble).
REQ-034 SHALL update d_o only on the accumulator write; d_o SHALL hold its value in IDLE.
REQ-035 SHALL use NCH = 1 when size_b=1 (single signed or unsigned bit).
REQ-036 SHALL clamp size_* values of 0 to 1 and values above MAX_WIDTH to MAX_WIDTH.

Reset
REQ-037 SHALL, on rst_i=1 at a clock edge, in any state including mid-COMPUTE:
- go to IDLE;
- clear valid_o, d_o, the chunk counter and the operand registers to 0;
- abandon any in-flight job with no output.
REQ-038 SHALL drive ready_o=1 in the first cycle after reset deasserts.

Structure
REQ-039 SHALL place in package seq_mac_pkg:
- FSM state enum;
- ACC_W=32;
- legal-P check function;
- chunk-count function.
REQ-040 SHALL instantiate one sub-module seq_mac_lane per (m,n): K-input chunk-product adder tree, shifter, accumulator, saturation.

Verification
REQ-041 SHALL cover: M=N=K=1, P=2, signed A=-3/size 4, signed B=5/size 4, C=10 -> d_o=-5, valid_o 3 cycles after acceptance.
REQ-042 SHALL cover: unsigned A=15, unsigned B=15, size 4/4, C=0 -> d_o=225.
REQ-043 SHALL cover: P=2, size_b=3, B=3'b101 signed, A=7, C=0 -> 2 chunks, d_o=-21.
REQ-044 SHALL cover: SATURATE=1, A=B=-32768/size 16, C=0x7FFFFFFF -> d_o=0x7FFFFFFF; same job with SATURATE=0 -> d_o=0xBFFFFFFF.
REQ-045 SHALL cover: ready_i held 0 for 5 cycles in DONE -> d_o and valid_o stable, ready_o=0; second job with accum_i=1 -> d_o = previous D + A*B.
REQ-046 SHALL cover: rst_i pulsed in COMPUTE cycle 1 -> valid_o never asserts for that job, d_o=0, ready_o=1 the next cycle.

Source files
------------

// File: rtl/seq_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_pkg
// Description : Shared types and helpers for the bit-serial matrix MAC.
//               Holds the controller state enum, the accumulator width, the
//               legal-P check, size clamping and the B chunk-count function.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mac_pkg;

    localparam int ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Only 1, 2 and 4 B bits per cycle are supported.
    function automatic bit p_is_legal(input int p);
        return (p == 1) || (p == 2) || (p == 4);
    endfunction

    // Out-of-range operand widths are pulled into 1..max_w.
    function automatic logic [4:0] clamp_size(input logic [4:0] size, input int max_w);
        if (size == 5'd0) begin
            return 5'd1;
        end
        if (int'(size) > max_w) begin
            return 5'(max_w);
        end
        return size;
    endfunction

    // ceil(size_b / p): number of COMPUTE cycles for one job.
    function automatic logic [4:0] num_chunks(input logic [4:0] size_b, input int p);
        return 5'((int'(size_b) + p - 1) / p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mac_v2_lane.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_lane
// Description : One output element D[m][n]. Forms the exact K-term sum of
//               A[k] * chunk(B[k]), shifts it into place and folds it into a
//               32-bit accumulator with either saturation or wrap-around.
// Ports       : clk_i, rst_i  - clock / synchronous active-high reset
//               load_i        - load accumulator from c_i
//               step_i        - add the current shifted chunk sum
//               c_i           - addend loaded at job start
//               a_i           - K extended A operands (signed, MAX_WIDTH+1 bits)
//               b_i           - K current B chunks (signed, P+1 bits)
//               shift_i       - chunk position in bits
//               acc_o         - accumulator value (drives D)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mac_lane
    import seq_mac_pkg::*;
#(
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int SATURATE  = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_i,
    input  logic                         step_i,
    input  logic [ACC_W-1:0]             c_i,
    input  logic [K-1:0][MAX_WIDTH:0]    a_i,
    input  logic [K-1:0][P:0]            b_i,
    input  logic [4:0]                   shift_i,
    output logic [ACC_W-1:0]             acc_o
);

    localparam int c_prod_w = MAX_WIDTH + P + 2;
    localparam int c_sum_w  = c_prod_w + $clog2(K);
    // Wide enough for the sum shifted by any 5-bit amount plus the accumulator.
    localparam int c_wide_w = c_sum_w + 33;

    logic signed [c_prod_w-1:0] w_prod [K];
    logic signed [c_sum_w-1:0]  w_sum;
    logic signed [c_wide_w-1:0] w_total;
    logic                       w_ovf;
    logic [ACC_W-1:0]           w_next;
    logic [ACC_W-1:0]           r_acc;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < K; k++) begin
            w_prod[k] = c_prod_w'($signed(a_i[k])) * c_prod_w'($signed(b_i[k]));
            w_sum     = w_sum + c_sum_w'(w_prod[k]);
        end
        w_total = c_wide_w'($signed(r_acc)) + (c_wide_w'(w_sum) <<< shift_i);
        // The exact result fits in 32 bits only if everything from bit 31 up
        // is a pure sign extension.
        w_ovf = !((&w_total[c_wide_w-1:ACC_W-1]) || !(|w_total[c_wide_w-1:ACC_W-1]));
        if ((SATURATE != 0) && w_ovf) begin
            w_next = w_total[c_wide_w-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_next = w_total[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else if (load_i) begin
            r_acc <= c_i;
        end else if (step_i) begin
            r_acc <= w_next;
        end
    end

    assign acc_o = r_acc;

endmodule
`default_nettype wire

// File: rtl/seq_mac_v2.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_v2
// Description : Bit-serial matrix multiply-accumulate D = A*B + C (or + D).
//               B is consumed P bits per cycle, LSB chunk first; the final
//               chunk carries the sign when B is signed.
// Ports       : clk_i, rst_i          - clock / synchronous active-high reset
//               a_i, b_i, c_i         - operand matrices (A, B right-aligned)
//               size_a_i, size_b_i    - operand widths (clamped to 1..MAX_WIDTH)
//               signed_a_i, signed_b_i- operand signedness
//               accum_i               - start from current D instead of C
//               valid_i / ready_o     - job input handshake
//               valid_o / ready_i     - result output handshake
//               d_o                   - result matrix
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mac_v2
    import seq_mac_pkg::*;
#(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    parameter int P         = 2,
    parameter int SATURATE  = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [M-1:0][K-1:0][MAX_WIDTH-1:0]  a_i,
    input  logic [K-1:0][N-1:0][MAX_WIDTH-1:0]  b_i,
    input  logic [M-1:0][N-1:0][ACC_W-1:0]      c_i,
    input  logic [4:0]                          size_a_i,
    input  logic [4:0]                          size_b_i,
    input  logic                                signed_a_i,
    input  logic                                signed_b_i,
    input  logic                                accum_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [M-1:0][N-1:0][ACC_W-1:0]      d_o
);

    generate
        if (!p_is_legal(P)) begin : g_bad_p
            $error("seq_mac_v2: P must be 1, 2 or 4");
        end
    endgenerate

    state_t                               r_state;
    logic [4:0]                           r_cnt;
    logic [4:0]                           r_size_a;
    logic [4:0]                           r_size_b;
    logic                                 r_signed_a;
    logic                                 r_signed_b;
    logic                                 r_valid;
    logic [M-1:0][K-1:0][MAX_WIDTH-1:0]   r_a;
    logic [K-1:0][N-1:0][MAX_WIDTH-1:0]   r_b;

    logic                                 w_accept;
    logic                                 w_load;
    logic                                 w_step;
    logic                                 w_last;
    logic [4:0]                           w_nch;
    logic [4:0]                           w_shamt;
    logic [MAX_WIDTH:0]                   w_mask_a;
    logic [MAX_WIDTH:0]                   w_top_a;
    logic [MAX_WIDTH:0]                   w_a_raw;
    logic [MAX_WIDTH+P-1:0]               w_mask_b;
    logic [MAX_WIDTH+P-1:0]               w_top_b;
    logic [MAX_WIDTH+P-1:0]               w_b_raw;
    logic [MAX_WIDTH+P-1:0]               w_b_ext;
    logic [P-1:0]                         w_b_chunk;
    logic [M-1:0][K-1:0][MAX_WIDTH:0]     w_a_ext;
    logic [N-1:0][K-1:0][P:0]             w_chunk;

    assign ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
    assign valid_o  = r_valid;
    assign w_accept = valid_i && ready_o;
    assign w_load   = w_accept && !accum_i;
    assign w_step   = (r_state == ST_COMPUTE);
    assign w_nch    = num_chunks(r_size_b, P);
    assign w_last   = (r_cnt == (w_nch - 5'd1));
    assign w_shamt  = 5'(int'(r_cnt) * P);

    // Operand extension by masking: bits at and above the width are replaced
    // by the sign bit (signed) or zero (unsigned).
    always_comb begin
        w_mask_a  = ~({(MAX_WIDTH+1){1'b1}} << r_size_a);
        w_top_a   = {{MAX_WIDTH{1'b0}}, 1'b1} << (r_size_a - 5'd1);
        w_mask_b  = ~({(MAX_WIDTH+P){1'b1}} << r_size_b);
        w_top_b   = {{(MAX_WIDTH+P-1){1'b0}}, 1'b1} << (r_size_b - 5'd1);
        w_a_raw   = '0;
        w_b_raw   = '0;
        w_b_ext   = '0;
        w_b_chunk = '0;
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                w_a_raw       = {1'b0, r_a[m][k]};
                w_a_ext[m][k] = (w_a_raw & w_mask_a) |
                                ((r_signed_a && (|(w_a_raw & w_top_a))) ? ~w_mask_a : '0);
            end
        end
        for (int k = 0; k < K; k++) begin
            for (int n = 0; n < N; n++) begin
                w_b_raw   = {{P{1'b0}}, r_b[k][n]};
                w_b_ext   = (w_b_raw & w_mask_b) |
                            ((r_signed_b && (|(w_b_raw & w_top_b))) ? ~w_mask_b : '0);
                w_b_chunk = P'(w_b_ext >> w_shamt);
                // Only the most significant chunk of a signed B is negative-weighted.
                w_chunk[n][k] = {r_signed_b && w_last && w_b_chunk[P-1], w_b_chunk};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_size_a   <= '0;
            r_size_b   <= '0;
            r_signed_a <= 1'b0;
            r_signed_b <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a        <= a_i;
                r_b        <= b_i;
                r_size_a   <= clamp_size(size_a_i, MAX_WIDTH);
                r_size_b   <= clamp_size(size_b_i, MAX_WIDTH);
                r_signed_a <= signed_a_i;
                r_signed_b <= signed_b_i;
                r_cnt      <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= valid_i ? ST_COMPUTE : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar m = 0; m < M; m++) begin : g_row
            for (genvar n = 0; n < N; n++) begin : g_col
                seq_mac_lane #(
                    .K         (K),
                    .MAX_WIDTH (MAX_WIDTH),
                    .P         (P),
                    .SATURATE  (SATURATE)
                ) u_lane (
                    .clk_i   (clk_i),
                    .rst_i   (rst_i),
                    .load_i  (w_load),
                    .step_i  (w_step),
                    .c_i     (c_i[m][n]),
                    .a_i     (w_a_ext[m]),
                    .b_i     (w_chunk[n]),
                    .shift_i (w_shamt),
                    .acc_o   (d_o[m][n])
                );
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_seq_mac_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mac_v2
// Description : Bench for seq_mac_v2. Two instances (saturating / wrapping)
//               share one stimulus stream; an arithmetic model predicts
//               handshakes and results each cycle, and directed jobs pin the
//               model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mac_v2;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int K  = 3;
    localparam int MW = 16;
    localparam int P  = 2;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_i, valid_i, ready_i, accum_i, signed_a_i, signed_b_i;
    logic [4:0] size_a_i, size_b_i;
    logic [M-1:0][K-1:0][MW-1:0] a_i;
    logic [K-1:0][N-1:0][MW-1:0] b_i;
    logic [M-1:0][N-1:0][31:0]   c_i;
    logic rdy_s, rdy_w, vld_s, vld_w;
    logic [M-1:0][N-1:0][31:0]   d_s, d_w;

    int n_checks = 0;
    int n_errors = 0;

    seq_mac_v2 #(.M(M), .N(N), .K(K), .MAX_WIDTH(MW), .P(P), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .size_a_i(size_a_i), .size_b_i(size_b_i), .signed_a_i(signed_a_i),
        .signed_b_i(signed_b_i), .accum_i(accum_i), .valid_i(valid_i),
        .ready_o(rdy_s), .valid_o(vld_s), .ready_i(ready_i), .d_o(d_s));

    seq_mac_v2 #(.M(M), .N(N), .K(K), .MAX_WIDTH(MW), .P(P), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
        .size_a_i(size_a_i), .size_b_i(size_b_i), .signed_a_i(signed_a_i),
        .signed_b_i(signed_b_i), .accum_i(accum_i), .valid_i(valid_i),
        .ready_o(rdy_w), .valid_o(vld_w), .ready_i(ready_i), .d_o(d_w));

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clampsz(input logic [4:0] s);
        if (s == 5'd0) return 1;
        if (int'(s) > MW) return MW;
        return int'(s);
    endfunction

    function automatic longint ext(input logic [MW-1:0] x, input int sz, input bit sg);
        longint v;
        v = longint'(x) & ((longint'(1) << sz) - 1);
        if (sg && (((v >> (sz - 1)) & 1) == 1)) v = v - (longint'(1) << sz);
        return v;
    endfunction

    function automatic longint fold(input longint t, input bit sat);
        if (sat) begin
            if (t > LMAX) return LMAX;
            if (t < LMIN) return LMIN;
            return t;
        end
        return longint'(int'(t));
    endfunction

    longint m_sat  [M][N];
    longint m_wrap [M][N];
    bit     m_init = 1'b0;
    bit     m_busy = 1'b0;
    bit     m_valid = 1'b0;
    int     m_left = 0;

    task automatic model_job();
        int sa, sb, nch;
        longint av, bv, ch, part, as_, aw;
        sa  = clampsz(size_a_i);
        sb  = clampsz(size_b_i);
        nch = (sb + P - 1) / P;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                as_ = accum_i ? m_sat[m][n]  : longint'($signed(c_i[m][n]));
                aw  = accum_i ? m_wrap[m][n] : longint'($signed(c_i[m][n]));
                for (int j = 0; j < nch; j++) begin
                    part = 0;
                    for (int k = 0; k < K; k++) begin
                        av = ext(a_i[m][k], sa, signed_a_i);
                        bv = ext(b_i[k][n], sb, signed_b_i);
                        ch = (bv >>> (j * P)) & ((longint'(1) << P) - 1);
                        if (signed_b_i && (j == nch - 1) && (ch >= (longint'(1) << (P - 1))))
                            ch = ch - (longint'(1) << P);
                        part = part + av * ch;
                    end
                    part = part * (longint'(1) << (j * P));
                    as_ = fold(as_ + part, 1'b1);
                    aw  = fold(aw + part, 1'b0);
                end
                m_sat[m][n]  = as_;
                m_wrap[m][n] = aw;
            end
        end
        m_left = nch;
    endtask

    // Compare current outputs, then advance the model across the coming edge.
    always @(negedge clk) begin : compare
        bit exp_ready;
        exp_ready = !m_busy && (!m_valid || ready_i);
        if (m_init) begin
            check32("ready_o_sat", 32'(rdy_s), 32'(exp_ready));
            check32("ready_o_wrap", 32'(rdy_w), 32'(exp_ready));
            check32("valid_o_sat", 32'(vld_s), 32'(m_valid));
            check32("valid_o_wrap", 32'(vld_w), 32'(m_valid));
            if (!m_busy) begin
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++) begin
                        check32($sformatf("d_sat[%0d][%0d]", m, n), d_s[m][n], 32'(m_sat[m][n]));
                        check32($sformatf("d_wrap[%0d][%0d]", m, n), d_w[m][n], 32'(m_wrap[m][n]));
                    end
            end
        end
        if (rst_i) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++) begin
                    m_sat[m][n]  = 0;
                    m_wrap[m][n] = 0;
                end
        end else if (m_init) begin
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                end
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
            if (valid_i && exp_ready) begin
                model_job();
                m_busy  = 1'b1;
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_job(input logic [MW-1:0] a00, input logic [MW-1:0] b00,
                           input logic [31:0] c00, input logic [4:0] sa, input logic [4:0] sb,
                           input bit sga, input bit sgb, input bit acc, input bit rdy,
                           output int lat);
        int guard;
        @(posedge clk); #1;
        a_i = '0; b_i = '0; c_i = '0;
        a_i[0][0] = a00; b_i[0][0] = b00; c_i[0][0] = c00;
        size_a_i = sa; size_b_i = sb; signed_a_i = sga; signed_b_i = sgb;
        accum_i = acc; ready_i = rdy; valid_i = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!rdy_s && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!vld_s && lat < 50);
        if (lat >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL job_timeout: got no valid_o expected valid_o within 50 cycles");
        end
    endtask

    initial begin
        int lat;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; accum_i = 1'b0;
        signed_a_i = 1'b0; signed_b_i = 1'b0; size_a_i = 5'd4; size_b_i = 5'd4;
        a_i = '0; b_i = '0; c_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check32("reset_ready_o", 32'(rdy_s), 32'd1);
        check32("reset_d_o", d_s[0][0], 32'd0);

        // signed -3 * signed 5 + 10; upper A bits are junk and must be ignored
        run_job(16'hABCD, 16'h0005, 32'd10, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, lat);
        check32("signed_small_sat", d_s[0][0], 32'hFFFF_FFFB);
        check32("signed_small_wrap", d_w[0][0], 32'hFFFF_FFFB);
        check32("latency_nch2", 32'(lat), 32'd3);

        run_job(16'h00FF, 16'h000F, 32'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, lat);
        check32("unsigned_15x15", d_s[0][0], 32'd225);

        // B = 3'b101 signed (-3), two chunks, the second signed
        run_job(16'h0007, 16'h0005, 32'd0, 5'd4, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        check32("odd_size_b_sat", d_s[0][0], 32'hFFFF_FFEB);
        check32("odd_size_b_wrap", d_w[0][0], 32'hFFFF_FFEB);
        check32("latency_nch2_odd", 32'(lat), 32'd3);

        run_job(16'h8000, 16'h8000, 32'h7FFF_FFFF, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, lat);
        check32("saturate_pos", d_s[0][0], 32'h7FFF_FFFF);
        check32("wrap_pos", d_w[0][0], 32'hBFFF_FFFF);
        check32("latency_nch8", 32'(lat), 32'd9);

        // Stall in DONE, then accumulate back-to-back
        run_job(16'd3, 16'd4, 32'd1, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check32("stall_valid_o", 32'(vld_s), 32'd1);
            check32("stall_ready_o", 32'(rdy_s), 32'd0);
            check32("stall_d_o", d_s[0][0], 32'd13);
            @(negedge clk);
        end
        run_job(16'd2, 16'd5, 32'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, lat);
        check32("accum_d_o", d_s[0][0], 32'd23);

        // Reset pulse during the second COMPUTE cycle
        @(posedge clk); #1;
        a_i[0][0] = 16'd9; b_i[0][0] = 16'd200; c_i[0][0] = 32'd77;
        size_a_i = 5'd8; size_b_i = 5'd8; signed_a_i = 1'b0; signed_b_i = 1'b0;
        accum_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        check32("rst_mid_ready_o", 32'(rdy_s), 32'd1);
        check32("rst_mid_d_o", d_s[0][0], 32'd0);
        for (int i = 0; i < 8; i++) begin
            check32("rst_mid_no_valid", 32'(vld_s), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic, checked every cycle by the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            rst_i      = ($urandom_range(0, 249) == 0);
            valid_i    = ($urandom_range(0, 2) != 0);
            ready_i    = ($urandom_range(0, 3) != 0);
            accum_i    = 1'($urandom_range(0, 1));
            signed_a_i = 1'($urandom_range(0, 1));
            signed_b_i = 1'($urandom_range(0, 1));
            size_a_i   = 5'($urandom_range(0, 20));
            size_b_i   = 5'($urandom_range(0, 20));
            for (int m = 0; m < M; m++)
                for (int k = 0; k < K; k++)
                    a_i[m][k] = 16'($urandom);
            for (int k = 0; k < K; k++)
                for (int n = 0; n < N; n++)
                    b_i[k][n] = 16'($urandom);
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++)
                    c_i[m][n] = $urandom;
        end
        @(posedge clk); #1;
        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
